// File: rtl/fluid_board_soc_onchip_mem_arbiter.sv
// fluid_board_soc_onchip_mem_arbiter
// Shares one 16-bit port of the on-chip dual-port RAM between two Avalon-MM
// style masters. At most one transfer is accepted per cycle. The selected
// command is registered toward the RAM. Read data comes back two cycles after
// accept and is tagged to the master that issued the read.
//
// Arbitration is round-robin. One master may keep the port for at most MAX_RUN
// consecutive accepted transfers while the other master is also requesting.
//
// Optional build macro: ONCHIP_ARB_FIXED_PRI_EN
//   defined   : m0 always wins when requesting (m1 may starve)
//   undefined : round-robin with bounded run length (default)
module fluid_board_soc_onchip_mem_arbiter #(
   parameter int MAX_RUN = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [13:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [1:0]  m0_byteenable,
   input  logic [15:0] m0_writedata,
   output logic        m0_waitrequest,
   output logic [15:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [13:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [1:0]  m1_byteenable,
   input  logic [15:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic [15:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [13:0] mem_address,
   output logic [1:0]  mem_byteenable,
   output logic [15:0] mem_writedata,
   output logic        mem_chipselect,
   output logic        mem_write,
   output logic        mem_clken,
   input  logic [15:0] mem_readdata
);

   localparam logic [3:0] C_MAX_RUN = 4'(MAX_RUN);

   // Request, grant and accept
   logic        w_req0;
   logic        w_req1;
   logic        w_grant;      // id of the winning master
   logic        w_accept;
   logic        w_wr_sel;
   logic [13:0] w_addr_sel;
   logic [1:0]  w_be_sel;
   logic [15:0] w_wd_sel;
   logic [3:0]  w_run_next;

   // Arbitration state. After reset last points at m1, so m0 wins first.
   logic        r_last;
   logic [3:0]  r_run;

   // Registered RAM command
   logic [13:0] r_mem_address;
   logic [1:0]  r_mem_byteenable;
   logic [15:0] r_mem_writedata;
   logic        r_mem_chipselect;
   logic        r_mem_write;
   logic        r_mem_clken;

   // Read tag pipeline {valid, id}, one stage per cycle of RAM latency
   logic        r_v1;
   logic        r_id1;
   logic        r_v2;
   logic        r_id2;

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;

   // Pick the winner from the requests, the last owner and the run length
`ifdef ONCHIP_ARB_FIXED_PRI_EN
   always_comb begin
      w_grant = r_last;
      if (w_req0) begin
         w_grant = 1'b0;
      end else begin
         w_grant = 1'b1;
      end
   end
`else
   always_comb begin
      w_grant = r_last;
      case ({w_req1, w_req0})
         2'b01: w_grant = 1'b0;
         2'b10: w_grant = 1'b1;
         2'b11: begin
            // run == 0 only right after reset: no run is in progress, so the
            // master other than last (m0) takes the port.
            if ((r_run != 4'd0) && (r_run < C_MAX_RUN)) begin
               w_grant = r_last;
            end else begin
               w_grant = ~r_last;
            end
         end
         default: w_grant = r_last;
      endcase
   end
`endif

   // Whenever anyone requests, the grant always lands on a requester,
   // so a request plus reset released means one transfer is accepted.
   assign w_accept = reset_n & (w_req0 | w_req1);

   assign m0_waitrequest = ~(reset_n & w_req0 & (w_grant == 1'b0));
   assign m1_waitrequest = ~(reset_n & w_req1 & (w_grant == 1'b1));

   // Route the winner's command fields; write wins over read when both are set
   always_comb begin
      w_wr_sel   = 1'b0;
      w_addr_sel = 14'd0;
      w_be_sel   = 2'b00;
      w_wd_sel   = 16'd0;
      if (w_grant) begin
         w_wr_sel   = m1_write;
         w_addr_sel = m1_address;
         w_be_sel   = m1_byteenable;
         w_wd_sel   = m1_writedata;
      end else begin
         w_wr_sel   = m0_write;
         w_addr_sel = m0_address;
         w_be_sel   = m0_byteenable;
         w_wd_sel   = m0_writedata;
      end
   end

   // Next run length: extend the current owner's run (saturating) or restart
   always_comb begin
      w_run_next = r_run;
      if (w_grant == r_last) begin
         if (r_run >= C_MAX_RUN) begin
            w_run_next = C_MAX_RUN;
         end else begin
            w_run_next = r_run + 4'd1;
         end
      end else begin
         w_run_next = 4'd1;
      end
   end

   // Arbitration state update, only on an accepted transfer
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_last <= 1'b1;
         r_run  <= 4'd0;
      end else if (w_accept) begin
         r_last <= w_grant;
         r_run  <= w_run_next;
      end else begin
         r_last <= r_last;
         r_run  <= r_run;
      end
   end

   // Stage 1: register the accepted command toward the RAM port
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_mem_address    <= 14'd0;
         r_mem_byteenable <= 2'b00;
         r_mem_writedata  <= 16'd0;
         r_mem_chipselect <= 1'b0;
         r_mem_write      <= 1'b0;
      end else if (w_accept) begin
         r_mem_address    <= w_addr_sel;
         r_mem_byteenable <= w_be_sel;
         r_mem_writedata  <= w_wd_sel;
         r_mem_chipselect <= 1'b1;
         r_mem_write      <= w_wr_sel;
      end else begin
         r_mem_chipselect <= 1'b0;
         r_mem_write      <= 1'b0;
      end
   end

   // RAM clock enable: low while in reset, high otherwise
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_mem_clken <= 1'b0;
      end else begin
         r_mem_clken <= 1'b1;
      end
   end

   // Tag pipeline: follow each accepted read to the cycle its data appears
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_v1  <= 1'b0;
         r_id1 <= 1'b0;
         r_v2  <= 1'b0;
         r_id2 <= 1'b0;
      end else begin
         r_v1  <= w_accept & ~w_wr_sel;
         r_id1 <= w_grant;
         r_v2  <= r_v1;
         r_id2 <= r_id1;
      end
   end

   assign mem_address      = r_mem_address;
   assign mem_byteenable   = r_mem_byteenable;
   assign mem_writedata    = r_mem_writedata;
   assign mem_chipselect   = r_mem_chipselect;
   assign mem_write        = r_mem_write;
   assign mem_clken        = r_mem_clken;

   assign m0_readdatavalid = r_v2 & (r_id2 == 1'b0);
   assign m1_readdatavalid = r_v2 & (r_id2 == 1'b1);
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_fluid_board_soc_onchip_mem_arbiter.sv
// Bench for fluid_board_soc_onchip_mem_arbiter with a behavioural 16K x 16
// RAM (registered address, unregistered q, byte enables) on the memory port.
module tb_fluid_board_soc_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [13:0] m0_address, m1_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [1:0]  m0_byteenable, m1_byteenable;
   logic [15:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [15:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [13:0] mem_address;
   logic [1:0]  mem_byteenable;
   logic [15:0] mem_writedata;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [15:0] mem_readdata;

   int checks = 0;
   int errors = 0;

   fluid_board_soc_onchip_mem_arbiter #(.MAX_RUN(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   always #5 clk = ~clk;

   // Behavioural RAM model
   logic [15:0] ram [0:16383];
   logic [13:0] ram_addr_r = 14'd0;

   function automatic logic [15:0] init_word(input logic [13:0] a);
      return 16'hC000 ^ {2'b00, a};
   endfunction

   always @(posedge clk) begin
      if (mem_clken) begin
         if (mem_chipselect && mem_write) begin
            if (mem_byteenable[0]) ram[mem_address][7:0]  = mem_writedata[7:0];
            if (mem_byteenable[1]) ram[mem_address][15:8] = mem_writedata[15:8];
         end
         ram_addr_r <= mem_address;
      end
   end
   assign mem_readdata = ram[ram_addr_r];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic m0r, input logic m0w, input logic [13:0] a0, input logic [15:0] wd0, input logic [1:0] be0,
                        input logic m1r, input logic m1w, input logic [13:0] a1, input logic [15:0] wd1, input logic [1:0] be1);
      m0_read = m0r; m0_write = m0w; m0_address = a0; m0_writedata = wd0; m0_byteenable = be0;
      m1_read = m1r; m1_write = m1w; m1_address = a1; m1_writedata = wd1; m1_byteenable = be1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 14'd0, 16'd0, 2'b11, 1'b0, 1'b0, 14'd0, 16'd0, 2'b11);
   endtask

   typedef struct packed {
      logic        m0r, m0w, m1r, m1w;
      logic [13:0] a0, a1;
      logic [15:0] wd0, wd1;
      logic        ew0, ew1;      // expected waitrequests this cycle
      logic        ecs, ewe;      // expected mem_chipselect / mem_write next cycle
      logic [13:0] eaddr;         // expected mem_address next cycle
   } vec_t;

   function automatic vec_t mk(input logic m0r, input logic m0w, input logic m1r, input logic m1w,
                               input logic [13:0] a0, input logic [13:0] a1,
                               input logic [15:0] wd0, input logic [15:0] wd1,
                               input logic ew0, input logic ew1, input logic ecs, input logic ewe,
                               input logic [13:0] ea);
      vec_t v;
      v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w;
      v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
      v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs; v.ewe = ewe; v.eaddr = ea;
      return v;
   endfunction

   vec_t vecs [18];

   initial begin
      logic        pv;
      logic        pid;
      logic [13:0] paddr;

      for (int i = 0; i < 16384; i++) ram[i] = init_word(14'(i));
      ram[14'h0123] = 16'hBEEF;
      ram[14'h3FFF] = 16'h1234;

      // Contention with MAX_RUN = 4 starting from reset: m0 x4, m1 x4, m0 ...
      vecs[0]  = mk(1'b1,1'b0,1'b1,1'b0, 14'h0010,14'h0020, 16'h0000,16'h0000, 1'b0,1'b1,1'b1,1'b0,14'h0010);
      vecs[1]  = mk(1'b1,1'b0,1'b1,1'b0, 14'h0011,14'h0021, 16'h0000,16'h0000, 1'b0,1'b1,1'b1,1'b0,14'h0011);
      vecs[2]  = mk(1'b1,1'b0,1'b1,1'b0, 14'h0012,14'h0022, 16'h0000,16'h0000, 1'b0,1'b1,1'b1,1'b0,14'h0012);
      vecs[3]  = mk(1'b1,1'b0,1'b1,1'b0, 14'h0013,14'h0023, 16'h0000,16'h0000, 1'b0,1'b1,1'b1,1'b0,14'h0013);
      vecs[4]  = mk(1'b1,1'b0,1'b1,1'b0, 14'h0014,14'h0024, 16'h0000,16'h0000, 1'b1,1'b0,1'b1,1'b0,14'h0024);
      vecs[5]  = mk(1'b1,1'b0,1'b1,1'b0, 14'h0015,14'h0025, 16'h0000,16'h0000, 1'b1,1'b0,1'b1,1'b0,14'h0025);
      vecs[6]  = mk(1'b1,1'b0,1'b1,1'b0, 14'h0016,14'h0026, 16'h0000,16'h0000, 1'b1,1'b0,1'b1,1'b0,14'h0026);
      vecs[7]  = mk(1'b1,1'b0,1'b1,1'b0, 14'h0017,14'h0027, 16'h0000,16'h0000, 1'b1,1'b0,1'b1,1'b0,14'h0027);
      vecs[8]  = mk(1'b1,1'b0,1'b1,1'b0, 14'h0018,14'h0028, 16'h0000,16'h0000, 1'b0,1'b1,1'b1,1'b0,14'h0018);
      // m1 alone, then m1 write, then nobody
      vecs[9]  = mk(1'b0,1'b0,1'b1,1'b0, 14'h0019,14'h0029, 16'h0000,16'h0000, 1'b1,1'b0,1'b1,1'b0,14'h0029);
      vecs[10] = mk(1'b0,1'b0,1'b0,1'b1, 14'h001A,14'h0200, 16'h0000,16'h7777, 1'b1,1'b0,1'b1,1'b1,14'h0200);
      vecs[11] = mk(1'b0,1'b0,1'b0,1'b0, 14'h001B,14'h002B, 16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b0,14'h0000);
      // read and write together is a write
      vecs[12] = mk(1'b1,1'b1,1'b0,1'b0, 14'h0300,14'h002C, 16'h4444,16'h0000, 1'b0,1'b1,1'b1,1'b1,14'h0300);
      // m0 owns with run 1 -> keeps 3 more under contention, then m1
      vecs[13] = mk(1'b1,1'b0,1'b1,1'b0, 14'h0031,14'h0032, 16'h0000,16'h0000, 1'b0,1'b1,1'b1,1'b0,14'h0031);
      vecs[14] = mk(1'b1,1'b0,1'b1,1'b0, 14'h0033,14'h0034, 16'h0000,16'h0000, 1'b0,1'b1,1'b1,1'b0,14'h0033);
      vecs[15] = mk(1'b1,1'b0,1'b1,1'b0, 14'h0035,14'h0036, 16'h0000,16'h0000, 1'b0,1'b1,1'b1,1'b0,14'h0035);
      vecs[16] = mk(1'b1,1'b0,1'b1,1'b0, 14'h0037,14'h0038, 16'h0000,16'h0000, 1'b1,1'b0,1'b1,1'b0,14'h0038);
      vecs[17] = mk(1'b0,1'b0,1'b0,1'b0, 14'h0000,14'h0000, 16'h0000,16'h0000, 1'b1,1'b1,1'b0,1'b0,14'h0000);

      // Reset held 3 cycles with both masters requesting
      reset_n = 1'b0;
      drive(1'b1, 1'b0, 14'h0001, 16'd0, 2'b11, 1'b1, 1'b0, 14'h0002, 16'd0, 2'b11);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_m0_wait", 16'(m0_waitrequest), 16'd1);
         chk("rst_m1_wait", 16'(m1_waitrequest), 16'd1);
         chk("rst_cs", 16'(mem_chipselect), 16'd0);
         chk("rst_clken", 16'(mem_clken), 16'd0);
         chk("rst_rdv0", 16'(m0_readdatavalid), 16'd0);
         chk("rst_rdv1", 16'(m1_readdatavalid), 16'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      idle();

`ifdef ONCHIP_ARB_FIXED_PRI_EN
      // Fixed priority: m0 wins every cycle, m1 starves
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 14'(16'h0050 + i), 16'd0, 2'b11, 1'b1, 1'b0, 14'h0060, 16'd0, 2'b11);
         #1;
         chk("fp_m0_wait", 16'(m0_waitrequest), 16'd0);
         chk("fp_m1_wait", 16'(m1_waitrequest), 16'd1);
         @(posedge clk); #1;
         chk("fp_addr", 16'(mem_address), 16'(16'h0050 + i));
      end
      @(negedge clk);
      idle();
`else
      // Table-driven vectors
      pv = 1'b0; pid = 1'b0; paddr = 14'd0;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         drive(vecs[k].m0r, vecs[k].m0w, vecs[k].a0, vecs[k].wd0, 2'b11,
               vecs[k].m1r, vecs[k].m1w, vecs[k].a1, vecs[k].wd1, 2'b11);
         #1;
         chk($sformatf("v%0d_m0_wait", k), 16'(m0_waitrequest), 16'(vecs[k].ew0));
         chk($sformatf("v%0d_m1_wait", k), 16'(m1_waitrequest), 16'(vecs[k].ew1));
         @(posedge clk); #1;
         chk($sformatf("v%0d_cs", k), 16'(mem_chipselect), 16'(vecs[k].ecs));
         chk($sformatf("v%0d_we", k), 16'(mem_write), 16'(vecs[k].ewe));
         if (vecs[k].ecs) chk($sformatf("v%0d_addr", k), 16'(mem_address), 16'(vecs[k].eaddr));
         chk($sformatf("v%0d_rdv0", k), 16'(m0_readdatavalid), 16'(pv & ~pid));
         chk($sformatf("v%0d_rdv1", k), 16'(m1_readdatavalid), 16'(pv & pid));
         if (pv) chk($sformatf("v%0d_rdata", k), (pid ? m1_readdata : m0_readdata), init_word(paddr));
         pv    = vecs[k].ecs & ~vecs[k].ewe;
         pid   = vecs[k].ew0;
         paddr = vecs[k].eaddr;
      end
      chk("clken_run", 16'(mem_clken), 16'd1);
      chk("ram_wr_m1", ram[14'h0200], 16'h7777);
      chk("ram_wr_m0", ram[14'h0300], 16'h4444);

      // Single read by m0 from 0x0123
      @(negedge clk);
      drive(1'b1, 1'b0, 14'h0123, 16'd0, 2'b11, 1'b0, 1'b0, 14'd0, 16'd0, 2'b11);
      #1;
      chk("sr_m0_wait", 16'(m0_waitrequest), 16'd0);
      @(posedge clk); #1;
      chk("sr_addr", 16'(mem_address), 16'h0123);
      chk("sr_rdv_early", 16'(m0_readdatavalid), 16'd0);
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      chk("sr_rdv0", 16'(m0_readdatavalid), 16'd1);
      chk("sr_rdv1", 16'(m1_readdatavalid), 16'd0);
      chk("sr_data", m0_readdata, 16'hBEEF);

      // Upper-byte write by m1 to 0x3FFF, then read back
      @(negedge clk);
      drive(1'b0, 1'b0, 14'd0, 16'd0, 2'b11, 1'b0, 1'b1, 14'h3FFF, 16'hA5FF, 2'b10);
      #1;
      chk("bw_m1_wait", 16'(m1_waitrequest), 16'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 14'd0, 16'd0, 2'b11, 1'b1, 1'b0, 14'h3FFF, 16'd0, 2'b11);
      #1;
      chk("br_m1_wait", 16'(m1_waitrequest), 16'd0);
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      chk("br_rdv1", 16'(m1_readdatavalid), 16'd1);
      chk("br_rdv0", 16'(m0_readdatavalid), 16'd0);
      chk("br_data", m1_readdata, 16'hA534);

      // Reset while an m1 read is in flight; m1 holds an unfinished run
      @(negedge clk);
      drive(1'b0, 1'b0, 14'd0, 16'd0, 2'b11, 1'b1, 1'b0, 14'h0041, 16'd0, 2'b11);
      @(negedge clk);
      reset_n = 1'b0;
      drive(1'b1, 1'b0, 14'h0042, 16'd0, 2'b11, 1'b1, 1'b0, 14'h0043, 16'd0, 2'b11);
      #1;
      chk("mr_m0_wait_forced", 16'(m0_waitrequest), 16'd1);
      chk("mr_m1_wait_forced", 16'(m1_waitrequest), 16'd1);
      @(posedge clk); #1;
      chk("mr_rdv0", 16'(m0_readdatavalid), 16'd0);
      chk("mr_rdv1", 16'(m1_readdatavalid), 16'd0);
      chk("mr_cs", 16'(mem_chipselect), 16'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("mr_first_m0_wait", 16'(m0_waitrequest), 16'd0);
      chk("mr_first_m1_wait", 16'(m1_waitrequest), 16'd1);
      @(posedge clk); #1;
      chk("mr_first_addr", 16'(mem_address), 16'h0042);
      @(negedge clk);
      idle();
`endif
      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
